// File: rtl/wide_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// wide_fifo_wr_arbiter
//
// Write-side controller for a wide FIFO built from C_NUMBER_FIFOS FIFO36_72
// slices (data width W = 64*C_NUMBER_FIFOS, parity width P = 8*C_NUMBER_FIFOS).
// After reset it sequences the FIFO's own reset (FIFO_RST high for C_RST_HOLD
// cycles, then C_RST_WAIT quiet cycles), then shares the single write port
// among C_NUM_PORTS AXI-Stream masters at packet granularity: round-robin
// search from a rotating pointer, grant locked until the TLAST beat.
// Accepted beats pass through one output register stage onto DI/DIP/WREN.
//
// Ports
//   clk_i               single clock, also the FIFO WRCLK
//   rst_i               synchronous, active-high reset
//   s_tdata_i           port i data at [(i+1)*W-1 -: W]
//   s_tkeep_i           port i byte enables (contiguous from LSB)
//   s_tlast_i           per-port end of packet
//   s_tvalid_i          per-port beat valid
//   s_tready_o          per-port beat ready (beat taken on TVALID & TREADY)
//   fifo_rst_o          FIFO RST
//   fifo_di_o           FIFO DI
//   fifo_dip_o          FIFO DIP: {0.., port[2:0], tlast, highest TKEEP index}
//   fifo_wren_o         FIFO WREN
//   fifo_almostfull_i   FIFO ALMOSTFULL (offset >= 3 covers pipeline latency)
//   fifo_wrerr_i        FIFO WRERR
//   init_done_o         high once reset sequencing has finished
//   wr_error_o          sticky: a FIFO write error was seen since reset
// -----------------------------------------------------------------------------
module wide_fifo_wr_arbiter #(
  parameter int C_NUMBER_FIFOS = 4,
  parameter int C_NUM_PORTS    = 4,
  parameter int C_RST_HOLD     = 5,
  parameter int C_RST_WAIT     = 4
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [C_NUM_PORTS*64*C_NUMBER_FIFOS-1:0]  s_tdata_i,
  input  logic [C_NUM_PORTS*8*C_NUMBER_FIFOS-1:0]   s_tkeep_i,
  input  logic [C_NUM_PORTS-1:0]                    s_tlast_i,
  input  logic [C_NUM_PORTS-1:0]                    s_tvalid_i,
  output logic [C_NUM_PORTS-1:0]                    s_tready_o,
  output logic                                      fifo_rst_o,
  output logic [64*C_NUMBER_FIFOS-1:0]              fifo_di_o,
  output logic [8*C_NUMBER_FIFOS-1:0]               fifo_dip_o,
  output logic                                      fifo_wren_o,
  input  logic                                      fifo_almostfull_i,
  input  logic                                      fifo_wrerr_i,
  output logic                                      init_done_o,
  output logic                                      wr_error_o
);

  localparam int W       = 64 * C_NUMBER_FIFOS;
  localparam int KB      = W / 8;                 // TKEEP bits per port
  localparam int P       = 8 * C_NUMBER_FIFOS;
  localparam int KW      = $clog2(KB);            // width of the TKEEP index field
  localparam int PW      = $clog2(C_NUM_PORTS);
  localparam int CNT_MAX = (C_RST_HOLD > C_RST_WAIT) ? C_RST_HOLD : C_RST_WAIT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_RST_HOLD,
    ST_RST_WAIT,
    ST_IDLE,
    ST_XFER
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   rr_q;
  logic [PW-1:0]   grant_q;
  logic            fifo_rst_q;
  logic            init_done_q;
  logic            wr_error_q;
  logic            wren_q;
  logic [W-1:0]    di_q;
  logic [P-1:0]    dip_q;

  logic [PW-1:0]   grant_d;
  logic            grant_found_d;
  logic [W-1:0]    beat_data;
  logic [KB-1:0]   beat_keep;
  logic            beat_last;
  logic            beat_accept;
  logic [KW-1:0]   keep_hi;
  logic [P-1:0]    dip_d;

  // Port index k places after base, wrapping modulo C_NUM_PORTS.
  function automatic logic [PW-1:0] port_after(input logic [PW-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= C_NUM_PORTS) sum = sum - C_NUM_PORTS;
    return sum[PW-1:0];
  endfunction

  // Round-robin search: first valid port at or after the rotating pointer.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    grant_d       = rr_q;
    grant_found_d = 1'b0;
    for (int k = 0; k < C_NUM_PORTS; k++) begin
      if (!grant_found_d && s_tvalid_i[port_after(rr_q, k)]) begin
        grant_found_d = 1'b1;
        grant_d       = port_after(rr_q, k);
      end
    end
  end

  // Beat of the granted port.
  assign beat_data   = s_tdata_i[int'(grant_q)*W +: W];
  assign beat_keep   = s_tkeep_i[int'(grant_q)*KB +: KB];
  assign beat_last   = s_tlast_i[grant_q];
  assign beat_accept = (state_q == ST_XFER) && s_tvalid_i[grant_q] && !fifo_almostfull_i;

  // ALMOSTFULL gates TREADY combinationally; the flag offset absorbs the
  // output register plus the FIFO's own flag latency.
  always_comb begin
    s_tready_o = '0;
    if (state_q == ST_XFER) s_tready_o[grant_q] = !fifo_almostfull_i;
  end

  // Sideband encoding: highest set TKEEP index (all-zero keep encodes 0),
  // then TLAST, then the source port index.
  always_comb begin
    keep_hi = '0;
    for (int b = 0; b < KB; b++) begin
      if (beat_keep[b]) keep_hi = KW'(b);
    end
    dip_d                 = '0;
    dip_d[KW-1:0]         = keep_hi;
    dip_d[KW]             = beat_last;
    dip_d[KW+3:KW+1]      = 3'(grant_q);
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples values from before this clock edge.
    if (rst_i) begin
      state_q     <= ST_RST_HOLD;
      cnt_q       <= '0;
      rr_q        <= '0;
      grant_q     <= '0;
      fifo_rst_q  <= 1'b1;
      init_done_q <= 1'b0;
      wr_error_q  <= 1'b0;
      wren_q      <= 1'b0;
      // NOTE: the wide data/parity registers are reset on purpose so the
      // FIFO inputs are defined zeros throughout reset sequencing.
      di_q        <= '0;
      dip_q       <= '0;
    end else begin
      wren_q <= 1'b0;
      if (fifo_wrerr_i) wr_error_q <= 1'b1;

      case (state_q)
        ST_RST_HOLD: begin
          if (cnt_q == CW'(C_RST_HOLD - 1)) begin
            state_q    <= ST_RST_WAIT;
            cnt_q      <= '0;
            fifo_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RST_WAIT: begin
          if (cnt_q == CW'(C_RST_WAIT - 1)) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_IDLE: begin
          if (grant_found_d) begin
            grant_q <= grant_d;
            state_q <= ST_XFER;
          end
        end

        ST_XFER: begin
          // Grant stays locked while TVALID is low; only TLAST releases it.
          if (beat_accept) begin
            wren_q <= 1'b1;
            di_q   <= beat_data;
            dip_q  <= dip_d;
            if (beat_last) begin
              state_q <= ST_IDLE;
              rr_q    <= port_after(grant_q, 1);
            end
          end
        end

        default: state_q <= ST_RST_HOLD;
      endcase
    end
  end

  assign fifo_rst_o  = fifo_rst_q;
  assign fifo_di_o   = di_q;
  assign fifo_dip_o  = dip_q;
  assign fifo_wren_o = wren_q;
  assign init_done_o = init_done_q;
  assign wr_error_o  = wr_error_q;

endmodule

// File: tb/tb_wide_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wide_fifo_wr_arbiter
//
// Self-checking bench. Per-port packet sources feed the arbiter; a
// transaction-level model (time since reset, current packet owner, rotating
// pointer, expected next FIFO write) predicts every output each cycle.
// Directed scenarios pin the model with literal expectations, then a long
// randomized run exercises valid gaps, backpressure, errors and resets.
// -----------------------------------------------------------------------------
module tb_wide_fifo_wr_arbiter;

  localparam int N    = 4;
  localparam int NF   = 4;
  localparam int W    = 64 * NF;
  localparam int KB   = W / 8;
  localparam int P    = 8 * NF;
  localparam int HOLD = 5;
  localparam int WAIT = 4;
  localparam int INIT = HOLD + WAIT;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  s_tdata;
  logic [N*KB-1:0] s_tkeep;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic            fifo_rst;
  logic [W-1:0]    fifo_di;
  logic [P-1:0]    fifo_dip;
  logic            fifo_wren;
  logic            fifo_af;
  logic            fifo_wrerr;
  logic            init_done;
  logic            wr_error;

  always #5 clk = ~clk;

  wide_fifo_wr_arbiter #(
    .C_NUMBER_FIFOS(NF),
    .C_NUM_PORTS   (N),
    .C_RST_HOLD    (HOLD),
    .C_RST_WAIT    (WAIT)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .s_tdata_i        (s_tdata),
    .s_tkeep_i        (s_tkeep),
    .s_tlast_i        (s_tlast),
    .s_tvalid_i       (s_tvalid),
    .s_tready_o       (s_tready),
    .fifo_rst_o       (fifo_rst),
    .fifo_di_o        (fifo_di),
    .fifo_dip_o       (fifo_dip),
    .fifo_wren_o      (fifo_wren),
    .fifo_almostfull_i(fifo_af),
    .fifo_wrerr_i     (fifo_wrerr),
    .init_done_o      (init_done),
    .wr_error_o       (wr_error)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- packet sources ----------------
  logic [W-1:0]  src_data[N];
  logic [KB-1:0] src_lastkeep[N];
  int            src_left[N];     // beats still to send; 0 = no packet
  bit            src_vmask[N];
  bit            gen_en, rand_valid, rand_misc;
  int            gen_beats;       // 0 = random length, else fixed and back-to-back
  logic          nx_af, nx_wrerr;

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [KB-1:0] src_keep(input int p);
    return (src_left[p] == 1) ? src_lastkeep[p] : {KB{1'b1}};
  endfunction

  task automatic start_packet(input int p, input int nb, input logic [KB-1:0] lk);
    src_left[p]     = nb;
    src_data[p]     = rand_word();
    src_lastkeep[p] = lk;
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < N; p++) begin
      s_tdata[p*W +: W]   = src_data[p];
      s_tkeep[p*KB +: KB] = src_keep(p);
      s_tlast[p]          = (src_left[p] == 1);
      s_tvalid[p]         = (src_left[p] > 0) && src_vmask[p];
    end
    fifo_af    = nx_af;
    fifo_wrerr = nx_wrerr;
  endtask

  // ---------------- behavioural model ----------------
  bit           model_ok = 1'b0;
  int           since_rst;        // clock edges since the reset edge
  int           owner;            // port holding the write port, -1 when arbitrating
  int           rr;
  bit           m_wren, m_wrerr;
  logic [W-1:0] m_di;
  logic [P-1:0] m_dip;
  bit           acc[N];

  // Sideband word: bits [4:0] highest TKEEP index, [5] last, [8:6] port.
  function automatic logic [P-1:0] exp_dip_f(input logic [KB-1:0] keep, input bit last, input int port);
    int hi = 0;
    for (int b = 0; b < KB; b++) if (keep[b]) hi = b;
    return P'(hi) + (P'(last) * 32) + (P'(port) * 64);
  endfunction

  // Recorded observations for the directed literal checks.
  bit           rec;
  logic [P-1:0] q_wdip[$];
  bit           q_wren[$];
  logic [N-1:0] q_tready[$];
  bit           q_frst[$];
  bit           q_init[$];

  task automatic rec_clear();
    q_wdip.delete(); q_wren.delete(); q_tready.delete(); q_frst.delete(); q_init.delete();
  endtask

  task automatic compare();
    logic [N-1:0] et;
    if (!model_ok) return;
    et = '0;
    if (owner >= 0 && !fifo_af) et[owner] = 1'b1;
    check("fifo_rst",  fifo_rst,  since_rst < HOLD);
    check("init_done", init_done, since_rst >= INIT);
    check("tready",    s_tready,  et);
    check("wren",      fifo_wren, m_wren);
    if (m_wren) begin
      check("di",  fifo_di,  m_di);
      check("dip", fifo_dip, m_dip);
    end
    check("wr_error", wr_error, m_wrerr);
    if (rec) begin
      q_wren.push_back(fifo_wren);
      if (fifo_wren) q_wdip.push_back(fifo_dip);
      q_tready.push_back(s_tready);
      q_frst.push_back(fifo_rst);
      q_init.push_back(init_done);
    end
  endtask

  // Advance the model across the coming clock edge using the inputs now applied.
  task automatic model_step();
    bit found;
    for (int p = 0; p < N; p++) acc[p] = 1'b0;
    if (rst) begin
      model_ok  = 1'b1;
      since_rst = 0;
      owner     = -1;
      rr        = 0;
      m_wren    = 1'b0;
      m_wrerr   = 1'b0;
      return;
    end
    if (!model_ok) return;
    m_wren = 1'b0;
    if (since_rst >= INIT) begin
      if (owner < 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && s_tvalid[(rr + k) % N]) begin
            found = 1'b1;
            owner = (rr + k) % N;
          end
        end
      end else if (s_tvalid[owner] && !fifo_af) begin
        acc[owner] = 1'b1;
        m_wren     = 1'b1;
        m_di       = src_data[owner];
        m_dip      = exp_dip_f(src_keep(owner), src_left[owner] == 1, owner);
        if (src_left[owner] == 1) begin
          rr    = (owner + 1) % N;
          owner = -1;
        end
      end
    end
    if (fifo_wrerr) m_wrerr = 1'b1;
    if (since_rst < 100000) since_rst++;
  endtask

  // Source bookkeeping after the edge; nothing here touches DUT pins directly.
  task automatic advance();
    int nbytes;
    logic [KB-1:0] one;
    one = 1;
    for (int p = 0; p < N; p++) begin
      if (acc[p]) begin
        src_left[p]--;
        if (src_left[p] > 0) src_data[p] = rand_word();
      end
      if (rst) src_left[p] = 0;
      if (gen_en && src_left[p] == 0) begin
        if (gen_beats > 0) begin
          start_packet(p, gen_beats, {KB{1'b1}});
        end else if ($urandom_range(0, 2) == 0) begin
          nbytes = $urandom_range(0, KB);
          start_packet(p, $urandom_range(1, 4), (one << nbytes) - one);
        end
      end
      if (rand_valid) src_vmask[p] = ($urandom_range(0, 3) != 0);
    end
    if (rand_misc) begin
      nx_af    = ($urandom_range(0, 4) == 0);
      nx_wrerr = ($urandom_range(0, 499) == 0);
    end
  endtask

  task automatic cycle();
    drive_inputs();
    @(negedge clk);
    compare();
    model_step();
    advance();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int hi_cnt, fall_idx, rise_idx, early, cnt, last_idx, diff;
    int widx[$];

    rst = 1'b1; nx_af = 1'b0; nx_wrerr = 1'b0;
    gen_en = 1'b0; rand_valid = 1'b0; rand_misc = 1'b0; gen_beats = 0; rec = 1'b0;
    for (int p = 0; p < N; p++) begin
      src_left[p] = 0; src_vmask[p] = 1'b1; src_data[p] = '0; src_lastkeep[p] = '1;
    end

    // T1: reset sequencing
    cycle();
    check("t1_rst_fifo_rst", fifo_rst, 1'b1);
    check("t1_rst_wren",     fifo_wren, 1'b0);
    check("t1_rst_di",       fifo_di, '0);
    check("t1_rst_dip",      fifo_dip, '0);
    check("t1_rst_init",     init_done, 1'b0);
    check("t1_rst_wr_error", wr_error, 1'b0);
    check("t1_rst_tready",   s_tready, '0);
    rst = 1'b0;
    rec_clear(); rec = 1'b1;
    repeat (11) cycle();
    rec = 1'b0;
    hi_cnt = 0; fall_idx = -1; rise_idx = -1; early = 0;
    for (int i = 0; i < q_frst.size(); i++) begin
      if (q_frst[i]) hi_cnt++;
      else if (fall_idx < 0) fall_idx = i;
      if (q_init[i] && rise_idx < 0) rise_idx = i;
      if (rise_idx < 0 && q_tready[i] != '0) early++;
    end
    check("t1_fifo_rst_cycles", hi_cnt, 5);
    check("t1_init_after_fall", rise_idx - fall_idx, 4);
    check("t1_no_early_tready", early, 0);

    // T2: single port, 3-beat packet, last keep = 16 bytes
    start_packet(2, 3, 32'h0000FFFF);
    rec_clear(); rec = 1'b1;
    for (int i = 0; i < 30 && src_left[2] > 0; i++) cycle();
    repeat (2) cycle();
    rec = 1'b0;
    check("t2_done", src_left[2], 0);
    check("t2_writes", q_wdip.size(), 3);
    if (q_wdip.size() == 3) begin
      check("t2_last_dip", q_wdip[2], 32'h0AF);
      check("t2_first_port", q_wdip[0][8:6], 3'd2);
    end

    // T3: fairness, all ports continuously valid with 2-beat packets
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    gen_en = 1'b1; gen_beats = 2;
    for (int p = 0; p < N; p++) start_packet(p, 2, {KB{1'b1}});
    rec_clear(); rec = 1'b1;
    repeat (45) cycle();
    rec = 1'b0; gen_en = 1'b0; gen_beats = 0;
    widx.delete();
    for (int i = 0; i < q_wren.size(); i++) if (q_wren[i]) widx.push_back(i);
    check("t3_enough_writes", widx.size() >= 16, 1'b1);
    if (widx.size() >= 16) begin
      for (int i = 0; i < 16; i++) check("t3_order", q_wdip[i][8:6], 3'(i / 2 % N));
      for (int i = 0; i < 7; i++) begin
        diff = widx[i+1] - widx[i];
        check("t3_gap", diff, (i % 2 == 0) ? 1 : 2);
      end
    end
    for (int i = 0; i < 100 && (src_left[0] + src_left[1] + src_left[2] + src_left[3]) > 0; i++) cycle();
    check("t3_drained", src_left[0] + src_left[1] + src_left[2] + src_left[3], 0);

    // T4: backpressure mid-packet for 10 cycles
    start_packet(0, 6, {KB{1'b1}});
    for (int i = 0; i < 30 && src_left[0] > 4; i++) cycle();
    check("t4_two_beats", src_left[0], 4);
    nx_af = 1'b1;
    rec_clear(); rec = 1'b1;
    repeat (10) cycle();
    nx_af = 1'b0; rec = 1'b0;
    cnt = 0;
    for (int i = 0; i < q_tready.size(); i++) if (q_tready[i] != '0) cnt++;
    check("t4_tready_low", cnt, 0);
    cnt = 0;
    for (int i = 1; i < q_wren.size(); i++) if (q_wren[i]) cnt++;
    check("t4_no_wren", cnt, 0);
    rec_clear(); rec = 1'b1;
    for (int i = 0; i < 30 && src_left[0] > 0; i++) cycle();
    repeat (2) cycle();
    rec = 1'b0;
    check("t4_resumed_writes", q_wdip.size(), 4);

    // T5: locked grant while the owner drops TVALID
    start_packet(1, 3, {KB{1'b1}});
    start_packet(3, 1, {KB{1'b1}});
    rec_clear(); rec = 1'b1;
    for (int i = 0; i < 30 && src_left[1] > 2; i++) cycle();
    src_vmask[1] = 1'b0;
    repeat (8) cycle();
    src_vmask[1] = 1'b1;
    for (int i = 0; i < 40 && (src_left[1] + src_left[3]) > 0; i++) cycle();
    repeat (2) cycle();
    rec = 1'b0;
    check("t5_writes", q_wdip.size(), 4);
    if (q_wdip.size() == 4) begin
      check("t5_port_w0", q_wdip[0][8:6], 3'd1);
      check("t5_port_w1", q_wdip[1][8:6], 3'd1);
      check("t5_port_w2", q_wdip[2][8:6], 3'd1);
      check("t5_port_w3", q_wdip[3][8:6], 3'd3);
    end

    // T6: reset mid-packet, then sticky write error
    start_packet(2, 4, {KB{1'b1}});
    for (int i = 0; i < 30 && src_left[2] > 3; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_fifo_rst_again", fifo_rst, 1'b1);
    check("t6_tready_cleared", s_tready, '0);
    check("t6_wren_cleared",   fifo_wren, 1'b0);
    repeat (12) cycle();
    check("t6_init_done", init_done, 1'b1);
    check("t6_no_error_yet", wr_error, 1'b0);
    nx_wrerr = 1'b1;
    cycle();
    nx_wrerr = 1'b0;
    repeat (5) cycle();
    check("t6_wr_error_sticky", wr_error, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_wr_error_cleared", wr_error, 1'b0);

    // Randomized run
    gen_en = 1'b1; rand_valid = 1'b1; rand_misc = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 799) == 0);
      cycle();
    end
    rst = 1'b0; gen_en = 1'b0; rand_valid = 1'b0; rand_misc = 1'b0;
    nx_af = 1'b0; nx_wrerr = 1'b0;
    for (int p = 0; p < N; p++) src_vmask[p] = 1'b1;
    for (int i = 0; i < 200 && (src_left[0] + src_left[1] + src_left[2] + src_left[3]) > 0; i++) cycle();
    repeat (2) cycle();
    check("rand_drained", src_left[0] + src_left[1] + src_left[2] + src_left[3], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
